// File: rtl/seq_chunk_adder.sv
// seq_chunk_adder: multi-cycle ripple add/sub, CHUNK bits per clock,
// valid/ready handshake on operand and result sides.
module seq_chunk_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int KW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [KW-1:0] KLAST = KW'(NCHUNK - 1);

  if (CHUNK < 1 || CHUNK > WIDTH) begin : g_bad_chunk
    $error("seq_chunk_adder: CHUNK out of range");
  end
  if (WIDTH % CHUNK != 0) begin : g_bad_width
    $error("seq_chunk_adder: WIDTH not a multiple of CHUNK");
  end

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic             carry;
  logic [KW-1:0]    k;
  logic [CHUNK-1:0] add_s;
  logic             add_c;
  logic             c_msb;
  logic             last;

  // Operands shift right so the live chunk is always at bit 0.
  always_comb begin
    {add_c, add_s} = {1'b0, ra[CHUNK-1:0]}
                   + {1'b0, rb[CHUNK-1:0]}
                   + {{CHUNK{1'b0}}, carry};
  end

  // Carry into the top bit recovered from that bit's sum.
  assign c_msb = ra[CHUNK-1] ^ rb[CHUNK-1] ^ add_s[CHUNK-1];
  assign last  = (k == KLAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (1'b1)
      (state == IDLE): begin
        in_ready = rst_n;
        if (in_valid) state_nx = RUN;
      end
      (state == RUN): begin
        busy = 1'b1;
        if (last) state_nx = DONE;
      end
      (state == DONE): begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ra    <= '0;
      rb    <= '0;
      carry <= 1'b0;
      k     <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      ra    <= a;
      rb    <= sub ? ~b : b;
      carry <= cin ^ sub;
      k     <= '0;
    end else if (state == RUN) begin
      sum[int'(k)*CHUNK +: CHUNK] <= add_s;
      ra    <= ra >> CHUNK;
      rb    <= rb >> CHUNK;
      carry <= add_c;
      k     <= k + KW'(1);
      if (last) begin
        cout <= add_c;
        ovf  <= c_msb ^ add_c;
      end
    end
  end

endmodule

// File: tb/tb_seq_chunk_adder.sv
// tb_seq_chunk_adder: table + random ops through a result scoreboard,
// plus backpressure, mid-op reset and CHUNK=WIDTH / CHUNK=1 sequences.
module tb_seq_chunk_adder;
  localparam int W = 32;
  localparam int C = 4;
  localparam int N = W / C;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } vec_t;

  typedef struct {
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } res_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         busy;

  logic [7:0] a8, b8, sum8a, sum8b;
  logic       cin8, sub8, iv8, or8;
  logic       ir8a, ov8a, co8a, of8a, bz8a;
  logic       ir8b, ov8b, co8b, of8b, bz8b;

  int   checks = 0;
  int   failures = 0;
  res_t sbq[$];

  always #5 clk = ~clk;

  seq_chunk_adder #(.WIDTH(W), .CHUNK(C)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .busy(busy)
  );

  seq_chunk_adder #(.WIDTH(8), .CHUNK(8)) d8a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv8), .in_ready(ir8a),
    .a(a8), .b(b8), .cin(cin8), .sub(sub8),
    .out_valid(ov8a), .out_ready(or8),
    .sum(sum8a), .cout(co8a), .ovf(of8a), .busy(bz8a)
  );

  seq_chunk_adder #(.WIDTH(8), .CHUNK(1)) d8b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv8), .in_ready(ir8b),
    .a(a8), .b(b8), .cin(cin8), .sub(sub8),
    .out_valid(ov8b), .out_ready(or8),
    .sum(sum8b), .cout(co8b), .ovf(of8b), .busy(bz8b)
  );

  task automatic chk(input string nm, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic ci, input logic sb);
    logic [W:0] f;
    res_t r;
    if (sb) begin
      f    = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, ci};
      r.s  = f[W-1:0];
      r.co = ~f[W];
      r.ov = (x[W-1] != y[W-1]) && (r.s[W-1] != x[W-1]);
    end else begin
      f    = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
      r.s  = f[W-1:0];
      r.co = f[W];
      r.ov = (x[W-1] == y[W-1]) && (r.s[W-1] != x[W-1]);
    end
    return r;
  endfunction

  function automatic vec_t mk(input logic [W-1:0] x, input logic [W-1:0] y,
                              input logic ci, input logic sb,
                              input logic [W-1:0] s, input logic co,
                              input logic ov);
    vec_t v;
    v.a = x; v.b = y; v.cin = ci; v.sub = sb;
    v.s = s; v.co = co; v.ov = ov;
    return v;
  endfunction

  // Called at a negedge with the DUT idle.
  task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] xb,
                        input logic xc, input logic xs,
                        input res_t e, input int hold);
    int   cyc;
    logic seen;
    res_t snap;
    res_t ex;
    chk("in_ready_idle", in_ready, 1);
    a = xa; b = xb; cin = xc; sub = xs;
    in_valid = 1'b1;
    sbq.push_back(e);
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 4 * N + 10) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        in_valid = 1'b0;
        a = $urandom; b = $urandom;
        cin = 1'($urandom); sub = 1'($urandom);
        chk("busy_run", busy, 1);
        chk("in_ready_run", in_ready, 0);
      end
      if (out_valid) seen = 1'b1;
    end
    chk("latency", cyc, N + 1);
    if (!seen) begin
      void'(sbq.pop_front());
      return;
    end
    snap.s = sum; snap.co = cout; snap.ov = ovf;
    for (int i = 0; i < hold; i++) begin
      if (i == 1) in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      chk("hold_valid", out_valid, 1);
      chk("hold_sum", sum, snap.s);
      chk("hold_cout", cout, snap.co);
      chk("hold_ovf", ovf, snap.ov);
      chk("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    ex = sbq.pop_front();
    chk("sum", sum, ex.s);
    chk("cout", cout, ex.co);
    chk("ovf", ovf, ex.ov);
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("out_valid_drop", out_valid, 0);
    chk("in_ready_back", in_ready, 1);
    chk("no_accept_on_done_edge", busy, 0);
    chk("sum_kept", sum, ex.s);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[8];
    res_t e;
    logic [W-1:0] ra, rb;
    logic rc, rs;
    int stale, la, lb;
    logic [7:0] sa, sb8;
    logic ca, cb, oa, ob;

    tbl[0] = mk(32'hFFFF_FFFF, 32'h0000_0001, 0, 0, 32'h0000_0000, 1, 0);
    tbl[1] = mk(32'h7FFF_FFFF, 32'h0000_0001, 0, 0, 32'h8000_0000, 0, 1);
    tbl[2] = mk(32'h1234_5678, 32'h1111_1111, 1, 0, 32'h2345_678A, 0, 0);
    tbl[3] = mk(32'h0000_0005, 32'h0000_0007, 0, 1, 32'hFFFF_FFFE, 0, 0);
    tbl[4] = mk(32'h8000_0000, 32'h0000_0001, 0, 1, 32'h7FFF_FFFF, 1, 1);
    tbl[5] = mk(32'h0000_000A, 32'h0000_0003, 1, 1, 32'h0000_0006, 1, 0);
    tbl[6] = mk(32'h0000_1234, 32'h0000_1234, 0, 1, 32'h0000_0000, 1, 0);
    tbl[7] = mk(32'h8000_0000, 32'h8000_0000, 0, 0, 32'h0000_0000, 1, 1);

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0;
    iv8 = 1'b0; or8 = 1'b1;

    @(negedge clk);
    chk("in_ready_in_reset", in_ready, 0);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", ovf, 0);
    rst_n = 1'b1;
    #1;
    chk("in_ready_after_rst", in_ready, 1);
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      e.s = tbl[i].s; e.co = tbl[i].co; e.ov = tbl[i].ov;
      run_op(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, e,
             (i == 2) ? 5 : 0);
    end

    for (int i = 0; i < 6; i++) begin
      ra = $urandom; rb = $urandom;
      rc = 1'($urandom); rs = 1'($urandom);
      run_op(ra, rb, rc, rs, model(ra, rb, rc, rs), i % 3);
    end

    // Abort at k=3: previous result (tbl-derived, cout=1) must be wiped.
    e = model(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, e, 0);
    a = 32'hDEAD_BEEF; b = 32'h0101_0101; cin = 1'b0; sub = 1'b0;
    in_valid = 1'b1;
    sbq.push_back(model(a, b, cin, sub));
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    sbq.delete();
    chk("abort_out_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_sum", sum, 0);
    chk("abort_cout", cout, 0);
    chk("abort_ovf", ovf, 0);
    rst_n = 1'b1;
    #1;
    chk("abort_in_ready", in_ready, 1);
    stale = 0;
    repeat (2 * N) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    chk("no_stale_result", stale, 0);
    run_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0,
           model(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0), 0);

    // Degenerate widths: CHUNK=WIDTH and CHUNK=1.
    chk("w8c8_in_ready", ir8a, 1);
    chk("w8c1_in_ready", ir8b, 1);
    a8 = 8'hF0; b8 = 8'h20; cin8 = 1'b0; sub8 = 1'b0;
    iv8 = 1'b1;
    la = 0; lb = 0;
    sa = '0; sb8 = '0; ca = 1'b0; cb = 1'b0; oa = 1'b0; ob = 1'b0;
    for (int cyc = 1; cyc <= 20 && (la == 0 || lb == 0); cyc++) begin
      @(negedge clk);
      if (cyc == 1) iv8 = 1'b0;
      if (ov8a && la == 0) begin
        la = cyc; sa = sum8a; ca = co8a; oa = of8a;
      end
      if (ov8b && lb == 0) begin
        lb = cyc; sb8 = sum8b; cb = co8b; ob = of8b;
      end
    end
    chk("w8c8_latency", la, 2);
    chk("w8c8_sum", sa, 8'h10);
    chk("w8c8_cout", ca, 1);
    chk("w8c8_ovf", oa, 0);
    chk("w8c1_latency", lb, 9);
    chk("w8c1_sum", sb8, 8'h10);
    chk("w8c1_cout", cb, 1);
    chk("w8c1_ovf", ob, 0);
    chk("scoreboard_empty", sbq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
